// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array tile sequencer: FSM encoding, array size
// and the drain-depth rule that ties pipeline depth to array skew.
package sa_pkg;

  localparam int SA_N = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } sa_state_e;

  // Zeros must cover the buffer latency plus the diagonal skew across the array.
  function automatic int drain_cyc(input int n, input int rd_lat);
    return rd_lat + 2 * (n - 1) + 1;
  endfunction

endpackage

// File: rtl/sa_tile_ctrl_if.sv
// Bundle of host control, operand-buffer read, array feed and result handshake signals
// around the tile sequencer; master is the sequencer side.
interface sa_tile_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int K_W    = 16
);
  logic              start;
  logic [K_W-1:0]    k_len;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] b_base;
  logic              abort;
  logic              busy;
  logic              a_rd_en;
  logic [ADDR_W-1:0] a_rd_addr;
  logic              b_rd_en;
  logic [ADDR_W-1:0] b_rd_addr;
  logic [31:0]       a_rd_data;
  logic [31:0]       b_rd_data;
  logic              sa_clear;
  logic [31:0]       sa_a_in;
  logic [31:0]       sa_b_in;
  logic              res_valid;
  logic              res_ready;

  modport master (
    input  start, k_len, a_base, b_base, abort, a_rd_data, b_rd_data, res_ready,
    output busy, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, sa_clear, sa_a_in, sa_b_in, res_valid
  );

  modport slave (
    output start, k_len, a_base, b_base, abort, a_rd_data, b_rd_data, res_ready,
    input  busy, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, sa_clear, sa_a_in, sa_b_in, res_valid
  );

endinterface

// File: rtl/sa_feed_pipe.sv
// Delays the read strobe by the buffer latency and zero-gates the returned A/B words,
// so the array only ever sees real operands or zeros.
module sa_feed_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        vld_in,
  input  logic [31:0] a_word,
  input  logic [31:0] b_word,
  output logic [31:0] a_out,
  output logic [31:0] b_out
);

  logic [RD_LAT-1:0] vld_p;

  function automatic logic [31:0] gate_word(input logic vld, input logic [31:0] w);
    return vld ? w : 32'd0;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (flush) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= vld_in;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // Stage RD_LAT: the strobe lines up with the buffer's returned word
  assign a_out = gate_word(vld_p[RD_LAT-1], a_word);
  assign b_out = gate_word(vld_p[RD_LAT-1], b_word);

endmodule

// File: rtl/sa_tile_ctrl.sv
// Tile sequencer: clear accumulators, stream k_len operand words, drain the array skew,
// then hold the result under valid/ready.
module sa_tile_ctrl
  import sa_pkg::*;
#(
  parameter int N      = SA_N,
  parameter int ADDR_W = 12,
  parameter int K_W    = 16,
  parameter int RD_LAT = 1
) (
  input logic            clk,
  input logic            rst_n,
  sa_tile_ctrl_if.master bus
);

  localparam int              DRAIN_CYC  = drain_cyc(N, RD_LAT);
  localparam int              DC_W       = $clog2(DRAIN_CYC + 1);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_CYC - 1);

  sa_state_e         state;
  sa_state_e         state_d;
  logic [K_W-1:0]    feed_rem;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [DC_W-1:0]   drain_cnt;
  logic              feed_en;
  logic              launch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    feed_en = 1'b0;
    unique case (state)
      ST_IDLE:  if (bus.start) state_d = ST_CLEAR;
      ST_CLEAR: state_d = (feed_rem != '0) ? ST_FEED : ST_DRAIN;
      ST_FEED: begin
        feed_en = 1'b1;
        if (feed_rem == K_W'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_d = ST_DONE;
      ST_DONE:  if (bus.res_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (bus.abort) state_d = ST_IDLE;
  end

  assign launch = (state == ST_IDLE) && bus.start && !bus.abort;

  // feed_rem counts reads still owed, so k_len = 2^K_W-1 fits without an extra bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feed_rem  <= '0;
      a_addr    <= '0;
      b_addr    <= '0;
      drain_cnt <= '0;
    end else begin
      if (launch) begin
        feed_rem <= bus.k_len;
        a_addr   <= bus.a_base;
        b_addr   <= bus.b_base;
      end else if (feed_en) begin
        feed_rem <= feed_rem - K_W'(1);
        a_addr   <= a_addr + ADDR_W'(1);
        b_addr   <= b_addr + ADDR_W'(1);
      end
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DC_W'(1) : '0;
    end
  end

  assign bus.busy      = (state != ST_IDLE);
  assign bus.sa_clear  = (state == ST_CLEAR);
  assign bus.a_rd_en   = feed_en;
  assign bus.b_rd_en   = feed_en;
  assign bus.a_rd_addr = a_addr;
  assign bus.b_rd_addr = b_addr;
  assign bus.res_valid = (state == ST_DONE);

  sa_feed_pipe #(
    .RD_LAT (RD_LAT)
  ) u_feed_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (bus.abort),
    .vld_in (feed_en),
    .a_word (bus.a_rd_data),
    .b_word (bus.b_rd_data),
    .a_out  (bus.sa_a_in),
    .b_out  (bus.sa_b_in)
  );

endmodule

// File: tb/tb_sa_tile_ctrl.sv
// Bench for sa_tile_ctrl: two builds (RD_LAT=1 and 2) with operand buffer and array models,
// checked against a scoreboard of expected reads, clears and results.
module tb_sa_tile_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   t0 = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int dut; int rel; logic [11:0] a; logic [11:0] b;} rd_t;
  typedef struct {int dut; int rel; logic [511:0] c;} res_t;
  rd_t  rd_q[$];
  rd_t  clr_q[$];
  res_t res_q[$];

  logic [31:0] a_mem[4096];
  logic [31:0] b_mem[4096];

  logic        start_v[2];
  logic [15:0] k_v[2];
  logic [11:0] ab_v[2];
  logic [11:0] bb_v[2];
  logic        abort_v[2];
  logic        ready_v[2];
  logic        pv[2];

  sa_tile_ctrl_if #(.ADDR_W(12), .K_W(16)) bus0 ();
  sa_tile_ctrl_if #(.ADDR_W(12), .K_W(16)) bus1 ();

  sa_tile_ctrl #(.N(4), .ADDR_W(12), .K_W(16), .RD_LAT(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  sa_tile_ctrl #(.N(4), .ADDR_W(12), .K_W(16), .RD_LAT(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus0.start = start_v[0];  assign bus1.start = start_v[1];
  assign bus0.k_len = k_v[0];      assign bus1.k_len = k_v[1];
  assign bus0.a_base = ab_v[0];    assign bus1.a_base = ab_v[1];
  assign bus0.b_base = bb_v[0];    assign bus1.b_base = bb_v[1];
  assign bus0.abort = abort_v[0];  assign bus1.abort = abort_v[1];
  assign bus0.res_ready = ready_v[0];
  assign bus1.res_ready = ready_v[1];

  // Operand buffers: garbage when not strobed, so missing zero-gating shows up in C
  logic [31:0] a0_p1, b0_p1, a1_p1, b1_p1, a1_p2, b1_p2;
  always @(posedge clk) begin
    a0_p1 <= bus0.a_rd_en ? a_mem[bus0.a_rd_addr] : 32'hDEADBEEF;
    b0_p1 <= bus0.b_rd_en ? b_mem[bus0.b_rd_addr] : 32'hBEEFDEAD;
    a1_p1 <= bus1.a_rd_en ? a_mem[bus1.a_rd_addr] : 32'hDEADBEEF;
    b1_p1 <= bus1.b_rd_en ? b_mem[bus1.b_rd_addr] : 32'hBEEFDEAD;
    a1_p2 <= a1_p1;
    b1_p2 <= b1_p1;
  end
  assign bus0.a_rd_data = a0_p1;  assign bus0.b_rd_data = b0_p1;
  assign bus1.a_rd_data = a1_p2;  assign bus1.b_rd_data = b1_p2;

  // Unskewed 4x4 outer-product accumulator: byte i of A word times byte j of B word into C[i][j]
  function automatic logic [511:0] mac(input logic [511:0] c, input logic clr,
                                       input logic [31:0] a, input logic [31:0] b);
    logic [511:0] r;
    int pa, pb;
    if (clr) return '0;
    r = c;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pa = int'($signed(a[8*i +: 8]));
        pb = int'($signed(b[8*j +: 8]));
        r[32*(4*i+j) +: 32] = r[32*(4*i+j) +: 32] + 32'(pa * pb);
      end
    end
    return r;
  endfunction

  logic [511:0] c0 = '0;
  logic [511:0] c1 = '0;
  always @(posedge clk) c0 <= mac(c0, bus0.sa_clear, bus0.sa_a_in, bus0.sa_b_in);
  always @(posedge clk) c1 <= mac(c1, bus1.sa_clear, bus1.sa_a_in, bus1.sa_b_in);

  function automatic logic [511:0] expc(input int ab, input int bb, input int k);
    logic [511:0] c = '0;
    for (int t = 0; t < k; t++) c = mac(c, 1'b0, a_mem[12'(ab + t)], b_mem[12'(bb + t)]);
    return c;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_one(input int d, input logic rda, input logic rdb, input logic [11:0] aa,
                         input logic [11:0] ba, input logic clr, input logic rv, input logic [511:0] c);
    rd_t  e;
    res_t r;
    int   rel;
    rel = cyc - t0;
    if (clr) begin
      if (clr_q.size() == 0) check("clr_unexpected", clr, 1'b0);
      else begin
        e = clr_q.pop_front();
        check("clr_dut", d, e.dut);
        check("clr_cycle", rel, e.rel);
      end
    end
    if (rda || rdb) begin
      if (rd_q.size() == 0) check("rd_unexpected", rda | rdb, 1'b0);
      else begin
        e = rd_q.pop_front();
        check("rd_dut", d, e.dut);
        check("rd_cycle", rel, e.rel);
        check("rd_both", {rda, rdb}, 2'b11);
        check("a_rd_addr", aa, e.a);
        check("b_rd_addr", ba, e.b);
      end
    end
    if (rv && !pv[d]) begin
      if (res_q.size() == 0) check("res_unexpected", rv, 1'b0);
      else begin
        r = res_q.pop_front();
        check("res_dut", d, r.dut);
        check("res_valid_cycle", rel, r.rel);
        check("res_c", c, r.c);
      end
    end
    pv[d] = rv;
  endtask

  task automatic do_start(input int d, input int k, input int ab, input int bb, input bit push_res);
    int dc;
    dc = (d == 1) ? 9 : 8;
    start_v[d] = 1'b1;
    k_v[d]     = 16'(k);
    ab_v[d]    = 12'(ab);
    bb_v[d]    = 12'(bb);
    t0 = cyc;
    clr_q.push_back('{d, 1, 12'd0, 12'd0});
    for (int i = 0; i < k; i++) rd_q.push_back('{d, 2 + i, 12'(ab + i), 12'(bb + i)});
    if (push_res) res_q.push_back('{d, k + 2 + dc, expc(ab, bb, k)});
    @(negedge clk);
    start_v[d] = 1'b0;
  endtask

  function automatic logic rv_of(input int d);
    return (d == 1) ? bus1.res_valid : bus0.res_valid;
  endfunction

  task automatic wait_rv(input int d, input string tag);
    int n = 0;
    while (!rv_of(d) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(tag, rv_of(d), 1'b1);
  endtask

  task automatic wait_rel(input int r);
    int n = 0;
    while ((cyc - t0) < r && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  logic [511:0] cap;

  initial begin
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0; k_v[d] = '0; ab_v[d] = '0; bb_v[d] = '0;
      abort_v[d] = 1'b0; ready_v[d] = 1'b1; pv[d] = 1'b0;
    end
    for (int i = 0; i < 4096; i++) begin
      a_mem[i] = $urandom;
      b_mem[i] = $urandom;
    end
    for (int t = 0; t < 4; t++) begin
      a_mem[12'h300 + t] = {8'(13 + t), 8'(9 + t), 8'(5 + t), 8'(1 + t)};
      b_mem[12'h400 + t] = 32'd1 << (8 * t);
    end
    fork
      forever begin
        @(negedge clk);
        mon_one(0, bus0.a_rd_en, bus0.b_rd_en, bus0.a_rd_addr, bus0.b_rd_addr,
                bus0.sa_clear, bus0.res_valid, c0);
        mon_one(1, bus1.a_rd_en, bus1.b_rd_en, bus1.a_rd_addr, bus1.b_rd_addr,
                bus1.sa_clear, bus1.res_valid, c1);
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_outputs_dut0", {bus0.busy, bus0.a_rd_en, bus0.a_rd_addr, bus0.b_rd_en, bus0.b_rd_addr,
                               bus0.sa_clear, bus0.sa_a_in, bus0.sa_b_in, bus0.res_valid}, '0);
    check("rst_outputs_dut1", {bus1.busy, bus1.a_rd_en, bus1.a_rd_addr, bus1.b_rd_en, bus1.b_rd_addr,
                               bus1.sa_clear, bus1.sa_a_in, bus1.sa_b_in, bus1.res_valid}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {bus0.busy, bus1.busy}, 2'b00);

    // Basic tile
    do_start(0, 4, 'h010, 'h020, 1'b1);
    check("t1_busy", bus0.busy, 1'b1);
    wait_rv(0, "t1_rv");
    @(negedge clk);
    check("t1_done_idle", {bus0.busy, bus0.res_valid}, 2'b00);
    check("t1_rdq_empty", rd_q.size(), 0);

    // Identity B
    do_start(0, 4, 'h300, 'h400, 1'b1);
    wait_rv(0, "t2_rv");
    check("t2_c12", c0[192 +: 32], 32'd7);
    check("t2_c30", c0[384 +: 32], 32'd13);
    @(negedge clk);

    // Zero-length reduction
    do_start(0, 0, 'h050, 'h060, 1'b1);
    wait_rv(0, "t3_rv");
    check("t3_c_zero", c0, '0);
    @(negedge clk);

    // Address wrap and back-pressure
    ready_v[0] = 1'b0;
    do_start(0, 4, 'hFFE, 'h0FF, 1'b1);
    wait_rv(0, "t4_rv");
    cap = c0;
    repeat (5) begin
      @(negedge clk);
      check("t4_hold_rv", bus0.res_valid, 1'b1);
      check("t4_hold_c", c0, cap);
      check("t4_hold_inputs", {bus0.sa_clear, bus0.sa_a_in, bus0.sa_b_in}, '0);
    end
    ready_v[0] = 1'b1;
    @(negedge clk);
    check("t4_handshake_idle", {bus0.busy, bus0.res_valid}, 2'b00);
    check("t4_rdq_empty", rd_q.size(), 0);

    // Abort in the third FEED cycle, then a clean tile
    do_start(0, 4, 'h100, 'h200, 1'b0);
    wait_rel(4);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    check("t5_abort_idle", {bus0.busy, bus0.a_rd_en, bus0.b_rd_en, bus0.sa_clear, bus0.res_valid}, '0);
    check("t5_abort_flush", {bus0.sa_a_in, bus0.sa_b_in}, '0);
    check("t5_abort_rd_left", rd_q.size(), 1);
    rd_q.delete();
    @(negedge clk);
    check("t5_abort_stays", {bus0.busy, bus0.a_rd_en}, 2'b00);
    do_start(0, 2, 'h100, 'h200, 1'b1);
    wait_rv(0, "t5_rv");
    @(negedge clk);

    // RD_LAT=2 build, start pulses while busy ignored
    do_start(1, 3, 'h500, 'h600, 1'b1);
    wait_rel(3);
    start_v[1] = 1'b1; k_v[1] = 16'd5; ab_v[1] = 12'h700; bb_v[1] = 12'h710;
    @(negedge clk);
    start_v[1] = 1'b0;
    wait_rel(8);
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    wait_rv(1, "t6_rv");
    @(negedge clk);
    check("t6_idle", bus1.busy, 1'b0);
    @(negedge clk);
    check("t6_not_queued", {bus1.busy, bus1.sa_clear}, 2'b00);
    check("t6_rdq_empty", rd_q.size(), 0);

    // Asynchronous reset mid-feed
    do_start(0, 4, 'h010, 'h020, 1'b0);
    wait_rel(3);
    #2 rst_n = 1'b0;
    #1;
    check("t7_async_rst", {bus0.busy, bus0.a_rd_en, bus0.b_rd_en, bus0.sa_a_in, bus0.sa_b_in}, '0);
    rd_q.delete();
    clr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t7_idle_after", bus0.busy, 1'b0);
    check("queues_drained", {16'(res_q.size()), 16'(clr_q.size())}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
